// File: rtl/ogege_text_pkg.sv
// Shared constants and bus payload types for the 8x12 text renderer.
package ogege_text_pkg;

  localparam int unsigned COLS       = 80;
  localparam int unsigned ROWS       = 40;
  localparam int unsigned GLYPH_W    = 8;
  localparam int unsigned GLYPH_H    = 12;
  localparam int unsigned H_ACTIVE   = COLS * GLYPH_W;
  localparam int unsigned V_ACTIVE   = ROWS * GLYPH_H;
  localparam int unsigned NUM_CELLS  = COLS * ROWS;
  localparam int unsigned FONT_DEPTH = 256 * GLYPH_H;
  localparam int unsigned PAL_DEPTH  = 16;

  localparam int unsigned CELL_W   = 16;
  localparam int unsigned CELL_AW  = 12;
  localparam int unsigned FONT_AW  = 12;
  localparam int unsigned PAL_AW   = 4;
  localparam int unsigned COLOR_W  = 12;

  // Cell word layout
  localparam int unsigned CELL_CHAR_LSB = 0;
  localparam int unsigned CELL_FG_LSB   = 8;
  localparam int unsigned CELL_BG_LSB   = 12;

  // row = (y * 683) >> 13 equals y / 12 for every y < 480
  localparam int unsigned ROW_RECIP_MUL   = 683;
  localparam int unsigned ROW_RECIP_SHIFT = 13;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_WCELL = 4'd1;
  localparam logic [3:0] OP_WPAL  = 4'd2;
  localparam logic [3:0] OP_FILL  = 4'd3;
  localparam logic [3:0] OP_WFONT = 4'd4;

  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] fg;
    logic [7:0] ch;
  } cell_word_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [11:0] addr;
    logic [15:0] data;
  } cmd_word_t;

endpackage

// File: rtl/text_cmd_ctrl.sv
// Command decode for the text renderer: cell/font/palette write ports and
// the IDLE/FILL sequencer that clears the cell RAM one word per cycle.
module text_cmd_ctrl
  import ogege_text_pkg::*;
#(
  parameter logic [15:0] FILL_WORD = 16'h0F20
) (
  input  logic                 i_pix_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_stb,
  input  logic [31:0]          i_cmd_data,
  output logic                 o_cmd_busy,
  output logic                 o_cell_we_c,
  output logic [CELL_AW-1:0]   o_cell_waddr_c,
  output logic [CELL_W-1:0]    o_cell_wdata_c,
  output logic                 o_font_we_c,
  output logic [FONT_AW-1:0]   o_font_waddr_c,
  output logic [7:0]           o_font_wdata_c,
  output logic                 o_pal_we_c,
  output logic [PAL_AW-1:0]    o_pal_waddr_c,
  output logic [COLOR_W-1:0]   o_pal_wdata_c
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_FILL = 1'b1;

  logic               state_q, state_d;
  logic [CELL_AW-1:0] idx_q, idx_d;
  logic [CELL_W-1:0]  fill_q, fill_d;
  logic               busy_q, busy_d;
  cmd_word_t          cmd;

  assign cmd        = cmd_word_t'(i_cmd_data);
  assign o_cmd_busy = busy_q;

  // Reset re-enters FILL so the screen is always cleared after reset
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      state_q <= ST_FILL;
      idx_q   <= '0;
      fill_q  <= FILL_WORD;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    fill_d         = fill_q;
    busy_d         = busy_q;
    o_cell_we_c    = 1'b0;
    o_cell_waddr_c = cmd.addr;
    o_cell_wdata_c = cmd.data;
    o_font_we_c    = 1'b0;
    o_font_waddr_c = cmd.addr;
    o_font_wdata_c = cmd.data[7:0];
    o_pal_we_c     = 1'b0;
    o_pal_waddr_c  = cmd.addr[PAL_AW-1:0];
    o_pal_wdata_c  = cmd.data[COLOR_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_stb) begin
          case (cmd.op)
            OP_WCELL: o_cell_we_c = (cmd.addr < CELL_AW'(NUM_CELLS));
            OP_WPAL:  o_pal_we_c  = 1'b1;
            OP_FILL: begin
              state_d = ST_FILL;
              idx_d   = '0;
              fill_d  = cmd.data;
              busy_d  = 1'b1;
            end
            OP_WFONT: o_font_we_c = (cmd.addr < FONT_AW'(FONT_DEPTH));
            default:  ;
          endcase
        end
      end
      ST_FILL: begin
        // Strobes are dropped for the whole fill, including its last cycle
        o_cell_we_c    = 1'b1;
        o_cell_waddr_c = idx_q;
        o_cell_wdata_c = fill_q;
        if (idx_q == CELL_AW'(NUM_CELLS - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + CELL_AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_rst) begin
      o_cell_we_c = 1'b0;
      o_font_we_c = 1'b0;
      o_pal_we_c  = 1'b0;
    end
  end

endmodule

// File: rtl/text_renderer8x12.sv
// Text-mode pixel stage: maps scrolled pixel coordinates to 8x12 glyph cells and
// emits palette colour three cycles later, with de/hsync/vsync delayed to match.
module text_renderer8x12
  import ogege_text_pkg::*;
#(
  parameter int unsigned HSZ       = 10,
  parameter int unsigned VSZ       = 9,
  parameter logic [15:0] FILL_WORD = 16'h0F20
) (
  input  logic               i_pix_clk,
  input  logic               i_rst,
  input  logic               i_de,
  input  logic               i_hsync,
  input  logic               i_vsync,
  input  logic [HSZ-1:0]     i_hcount,
  input  logic [VSZ-1:0]     i_vcount,
  input  logic [HSZ-1:0]     i_scroll_x,
  input  logic [VSZ-1:0]     i_scroll_y,
  input  logic               i_cmd_stb,
  input  logic [31:0]        i_cmd_data,
  output logic               o_cmd_busy,
  output logic               o_de,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic [COLOR_W-1:0] o_color
);

  localparam int unsigned XW = HSZ + 1;
  localparam int unsigned YW = VSZ + 1;

  logic                 cell_we_c;
  logic [CELL_AW-1:0]   cell_waddr_c;
  logic [CELL_W-1:0]    cell_wdata_c;
  logic                 font_we_c;
  logic [FONT_AW-1:0]   font_waddr_c;
  logic [7:0]           font_wdata_c;
  logic                 pal_we_c;
  logic [PAL_AW-1:0]    pal_waddr_c;
  logic [COLOR_W-1:0]   pal_wdata_c;

  text_cmd_ctrl #(
    .FILL_WORD (FILL_WORD)
  ) u_cmd_ctrl (
    .i_pix_clk      (i_pix_clk),
    .i_rst          (i_rst),
    .i_cmd_stb      (i_cmd_stb),
    .i_cmd_data     (i_cmd_data),
    .o_cmd_busy     (o_cmd_busy),
    .o_cell_we_c    (cell_we_c),
    .o_cell_waddr_c (cell_waddr_c),
    .o_cell_wdata_c (cell_wdata_c),
    .o_font_we_c    (font_we_c),
    .o_font_waddr_c (font_waddr_c),
    .o_font_wdata_c (font_wdata_c),
    .o_pal_we_c     (pal_we_c),
    .o_pal_waddr_c  (pal_waddr_c),
    .o_pal_wdata_c  (pal_wdata_c)
  );

  logic [CELL_W-1:0]  cell_mem [NUM_CELLS];
  logic [7:0]         font_mem [FONT_DEPTH];
  logic [COLOR_W-1:0] pal_q    [PAL_DEPTH];

  // S0: scroll wrap and cell coordinate arithmetic
  logic [XW-1:0]      x_sum_c;
  logic [YW-1:0]      y_sum_c;
  logic [HSZ-1:0]     x_c;
  logic [VSZ-1:0]     y_c;
  logic [5:0]         row_c;
  logic [3:0]         grow_c;
  logic [6:0]         col_c;
  logic [CELL_AW-1:0] cell_addr_c;

  always_comb begin
    x_sum_c     = XW'(i_hcount) + XW'(i_scroll_x);
    y_sum_c     = YW'(i_vcount) + YW'(i_scroll_y);
    x_c         = (x_sum_c >= XW'(H_ACTIVE)) ? HSZ'(x_sum_c - XW'(H_ACTIVE)) : HSZ'(x_sum_c);
    y_c         = (y_sum_c >= YW'(V_ACTIVE)) ? VSZ'(y_sum_c - YW'(V_ACTIVE)) : VSZ'(y_sum_c);
    col_c       = 7'(x_c >> 3);
    row_c       = 6'((32'(y_c) * ROW_RECIP_MUL) >> ROW_RECIP_SHIFT);
    grow_c      = 4'(32'(y_c) - 32'(row_c) * GLYPH_H);
    cell_addr_c = CELL_AW'({row_c, 6'd0}) + CELL_AW'({row_c, 4'd0}) + CELL_AW'(col_c);
  end

  logic [CELL_AW-1:0] addr_s0;
  logic [2:0]         xbit_s0, xbit_s1;
  logic [3:0]         grow_s0, grow_s1;
  cell_word_t         cell_s1;

  always_ff @(posedge i_pix_clk) begin
    addr_s0 <= cell_addr_c;
    xbit_s0 <= x_c[2:0];
    grow_s0 <= grow_c;
    xbit_s1 <= xbit_s0;
    grow_s1 <= grow_s0;
  end

  // S1: cell RAM, read-first when a write hits the same address
  always_ff @(posedge i_pix_clk) begin
    if (cell_we_c) begin
      cell_mem[cell_waddr_c] <= cell_wdata_c;
    end
    cell_s1 <= cell_word_t'(cell_mem[addr_s0]);
  end

  always_ff @(posedge i_pix_clk) begin
    if (font_we_c) begin
      font_mem[font_waddr_c] <= font_wdata_c;
    end
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 16; i++) begin
        pal_q[i] <= {4'(i), 4'(i), 4'(i)};
      end
    end else if (pal_we_c) begin
      pal_q[pal_waddr_c] <= pal_wdata_c;
    end
  end

  // S2: glyph row and palette lookup, folded into the output register
  logic [FONT_AW-1:0] font_raddr_c;
  logic [7:0]         font_byte_c;
  logic               pix_on_c;
  logic [COLOR_W-1:0] fg_c;
  logic [COLOR_W-1:0] bg_c;

  always_comb begin
    font_raddr_c = FONT_AW'({cell_s1.ch, 3'd0}) + FONT_AW'({cell_s1.ch, 2'd0})
                 + FONT_AW'(grow_s1);
    font_byte_c  = font_mem[font_raddr_c];
    pix_on_c     = font_byte_c[3'd7 - xbit_s1];
    fg_c         = pal_q[cell_s1.fg];
    bg_c         = pal_q[cell_s1.bg];
  end

  logic [2:0]         de_pipe, hs_pipe, vs_pipe;
  logic [COLOR_W-1:0] color_q;

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      de_pipe <= '0;
      hs_pipe <= '1;
      vs_pipe <= '1;
      color_q <= '0;
    end else begin
      de_pipe <= {de_pipe[1:0], i_de};
      hs_pipe <= {hs_pipe[1:0], i_hsync};
      vs_pipe <= {vs_pipe[1:0], i_vsync};
      color_q <= de_pipe[1] ? (pix_on_c ? fg_c : bg_c) : '0;
    end
  end

  assign o_de    = de_pipe[2];
  assign o_hsync = hs_pipe[2];
  assign o_vsync = vs_pipe[2];
  assign o_color = color_q;

endmodule

// File: tb/tb_text_renderer8x12.sv
// Randomised bench for text_renderer8x12 against a divide/modulo reference of
// the text screen (cells, font, palette) kept in plain arrays.
module tb_text_renderer8x12;

  logic        clk_pix = 1'b0;
  logic        rst;
  logic        de, hsync, vsync;
  logic [9:0]  hcount, scroll_x;
  logic [8:0]  vcount, scroll_y;
  logic        cmd_stb;
  logic [31:0] cmd_data;
  logic        cmd_busy;
  logic        o_de, o_hsync, o_vsync;
  logic [11:0] o_color;

  always #5 clk_pix = ~clk_pix;

  text_renderer8x12 dut (
    .i_pix_clk  (clk_pix),
    .i_rst      (rst),
    .i_de       (de),
    .i_hsync    (hsync),
    .i_vsync    (vsync),
    .i_hcount   (hcount),
    .i_vcount   (vcount),
    .i_scroll_x (scroll_x),
    .i_scroll_y (scroll_y),
    .i_cmd_stb  (cmd_stb),
    .i_cmd_data (cmd_data),
    .o_cmd_busy (cmd_busy),
    .o_de       (o_de),
    .o_hsync    (o_hsync),
    .o_vsync    (o_vsync),
    .o_color    (o_color)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference screen state
  logic [15:0] m_cell [3200];
  logic [7:0]  m_font [3072];
  logic [11:0] m_pal  [16];
  bit          fill_active;

  typedef struct {
    bit de;
    bit hs;
    bit vs;
    int h;
    int v;
  } stim_t;

  stim_t       stim_q[$];
  logic [11:0] obs_q[$];

  function automatic logic [11:0] model_pix(input int h, input int v);
    int          x, y;
    logic [15:0] c;
    logic [7:0]  f;
    x = (h + int'(scroll_x)) % 640;
    y = (v + int'(scroll_y)) % 480;
    c = m_cell[(y / 12) * 80 + x / 8];
    f = m_font[int'(c[7:0]) * 12 + y % 12];
    return f[7 - x % 8] ? m_pal[c[11:8]] : m_pal[c[15:12]];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3200; i++) m_cell[i] = 16'h0F20;
    for (int i = 0; i < 16; i++) m_pal[i] = {4'(i), 4'(i), 4'(i)};
    fill_active = 1'b1;
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [11:0] addr, input logic [15:0] data);
    @(negedge clk_pix);
    cmd_stb  = 1'b1;
    cmd_data = {op, addr, data};
    if (!fill_active) begin
      case (op)
        4'd1: if (addr < 12'd3200) m_cell[addr] = data;
        4'd2: m_pal[addr[3:0]] = data[11:0];
        4'd3: begin
          for (int i = 0; i < 3200; i++) m_cell[i] = data;
          fill_active = 1'b1;
        end
        4'd4: if (addr < 12'd3072) m_font[addr] = data[7:0];
        default: ;
      endcase
    end
    @(negedge clk_pix);
    cmd_stb = 1'b0;
  endtask

  // Counts busy cycles; optionally fires strobes mid-fill and on its last cycle
  task automatic wait_busy(input string tag, input bit drop);
    int cnt = 0;
    while (cmd_busy === 1'b1 && cnt < 5000) begin
      cnt++;
      cmd_stb  = drop && (cnt == 5 || cnt == 3200);
      cmd_data = (cnt == 5) ? {4'd1, 12'd7, 16'h1234} : {4'd2, 12'd15, 16'h0ABC};
      @(negedge clk_pix);
    end
    cmd_stb = 1'b0;
    check_eq(tag, 32'(cnt), 32'd3200);
    fill_active = 1'b0;
  endtask

  task automatic drive_idle();
    de = 1'b0; hsync = 1'b1; vsync = 1'b1; hcount = '0; vcount = '0;
  endtask

  task automatic push_pix(input bit d, input int h, input int v);
    stim_t s;
    s.de = d; s.hs = 1'($urandom); s.vs = 1'($urandom); s.h = h; s.v = v;
    stim_q.push_back(s);
  endtask

  task automatic gen_random(input int n, input int de_pct);
    for (int i = 0; i < n; i++) begin
      if (int'($urandom_range(99)) < de_pct)
        push_pix(1'b1, int'($urandom_range(639)), int'($urandom_range(479)));
      else
        push_pix(1'b0, int'($urandom_range(799)), int'($urandom_range(524)));
    end
  endtask

  // Streams stim_q through the DUT; outputs are compared three cycles later
  task automatic run_stim(input string tag);
    logic [14:0] exp_q[$];
    logic [14:0] e;
    stim_t       s;
    int          n;
    n = stim_q.size();
    obs_q.delete();
    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk_pix);
      if (i >= 3) begin
        e = exp_q.pop_front();
        check_eq({tag, "_de"}, 32'(o_de), 32'(e[14]));
        check_eq({tag, "_hs"}, 32'(o_hsync), 32'(e[13]));
        check_eq({tag, "_vs"}, 32'(o_vsync), 32'(e[12]));
        check_eq({tag, "_color"}, 32'(o_color), 32'(e[11:0]));
        obs_q.push_back(o_color);
      end
      if (i < n) begin
        s = stim_q.pop_front();
        de = s.de; hsync = s.hs; vsync = s.vs;
        hcount = 10'(s.h); vcount = 9'(s.v);
        exp_q.push_back({s.de, s.hs, s.vs, s.de ? model_pix(s.h, s.v) : 12'h000});
      end else begin
        drive_idle();
        exp_q.push_back({1'b0, 1'b1, 1'b1, 12'h000});
      end
    end
    drive_idle();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_stb = 1'b0; cmd_data = '0;
    scroll_x = '0; scroll_y = '0;
    de = 1'b1; hsync = 1'b0; vsync = 1'b0; hcount = '0; vcount = '0;
    model_reset();
    repeat (4) @(negedge clk_pix);
    check_eq("rst_de", 32'(o_de), 32'd0);
    check_eq("rst_hs", 32'(o_hsync), 32'd1);
    check_eq("rst_vs", 32'(o_vsync), 32'd1);
    check_eq("rst_color", 32'(o_color), 32'd0);
    check_eq("rst_busy", 32'(cmd_busy), 32'd1);
    drive_idle();
    @(negedge clk_pix);
    rst = 1'b0;
    wait_busy("rst_busy_len", 1'b0);

    // Blank glyph for the fill character gives a black screen
    for (int r = 0; r < 12; r++) send_cmd(4'd4, 12'(32 * 12 + r), 16'h0000);
    gen_random(400, 100);
    run_stim("t1");
    foreach (obs_q[i]) if (i < 20) check_eq("t1_black", 32'(obs_q[i]), 32'h000);

    // Single lit pixel at the top-left of cell 0
    for (int r = 1; r < 12; r++) send_cmd(4'd4, 12'(65 * 12 + r), 16'h0000);
    send_cmd(4'd4, 12'(65 * 12), 16'h0080);
    send_cmd(4'd1, 12'd0, 16'h0F41);
    push_pix(1'b1, 0, 0);
    push_pix(1'b1, 1, 0);
    push_pix(1'b1, 0, 1);
    run_stim("t2");
    check_eq("t2_p00", 32'(obs_q[0]), 32'hFFF);
    check_eq("t2_p10", 32'(obs_q[1]), 32'h000);
    check_eq("t2_p01", 32'(obs_q[2]), 32'h000);

    gen_random(500, 50);
    run_stim("t3");

    // Populate font, cells and palette randomly, plus commands that must be ignored
    for (int a = 0; a < 3072; a++) send_cmd(4'd4, 12'(a), 16'($urandom));
    for (int i = 0; i < 300; i++) send_cmd(4'd1, 12'($urandom_range(3199)), 16'($urandom));
    for (int i = 0; i < 6; i++) send_cmd(4'd2, 12'($urandom_range(15)), 16'($urandom));
    send_cmd(4'd1, 12'd3200, 16'hFFFF);
    send_cmd(4'd4, 12'd3072, 16'h00FF);
    for (int op = 5; op < 16; op++) send_cmd(4'(op), 12'd0, 16'hFFFF);
    send_cmd(4'd9, 12'd1, 16'h7777);
    send_cmd(4'd0, 12'd2, 16'h5555);
    for (int k = 0; k < 5; k++) begin
      scroll_x = (k == 4) ? 10'd639 : 10'($urandom_range(639));
      scroll_y = (k == 4) ? 9'd479 : 9'($urandom_range(479));
      gen_random(300, 85);
      run_stim("rand");
    end

    // Scroll wrap boundaries
    scroll_x = 10'd8; scroll_y = '0;
    push_pix(1'b1, 632, 0); push_pix(1'b1, 639, 0); push_pix(1'b1, 0, 0);
    run_stim("t4_sx8");
    scroll_x = '0; scroll_y = 9'd12;
    for (int h = 0; h < 16; h++) push_pix(1'b1, h, 0);
    push_pix(1'b1, 100, 467);
    run_stim("t4_sy12");
    scroll_y = 9'd1;
    for (int h = 0; h < 16; h++) push_pix(1'b1, h, 479);
    run_stim("t4_sy1");
    scroll_x = '0; scroll_y = '0;

    // Fill with strobes dropped while busy, then sweep every cell
    send_cmd(4'd3, 12'd0, 16'h1F41);
    wait_busy("t5_busy_len", 1'b1);
    for (int c = 0; c < 3200; c++)
      push_pix(1'b1, (c % 80) * 8 + int'($urandom_range(7)), (c / 80) * 12 + int'($urandom_range(11)));
    run_stim("t5_sweep");

    // Reset part-way through a fill restarts it with the reset word
    send_cmd(4'd3, 12'd0, 16'h2233);
    repeat (999) @(negedge clk_pix);
    check_eq("t5_mid_busy", 32'(cmd_busy), 32'd1);
    rst = 1'b1;
    model_reset();
    @(negedge clk_pix);
    rst = 1'b0;
    wait_busy("t5_rst_busy_len", 1'b0);
    gen_random(400, 90);
    run_stim("t5_post");

    // Palette rewrite of entry 15
    for (int r = 0; r < 12; r++) send_cmd(4'd4, 12'(32 * 12 + r), 16'h00FF);
    gen_random(200, 100);
    run_stim("t6_pre");
    foreach (obs_q[i]) if (i < 10) check_eq("t6_white", 32'(obs_q[i]), 32'hFFF);
    send_cmd(4'd2, 12'd15, 16'h0F00);
    gen_random(200, 100);
    run_stim("t6_post");
    foreach (obs_q[i]) if (i < 10) check_eq("t6_red", 32'(obs_q[i]), 32'hF00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
